inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
Instruction-fetch sequencer for the combinational instruction ROM.
- Owns the fetch PC and drives the ROM address each cycle.
- Captures the returned word with its PC into a small fetch queue.
- Presents instructions to decode over a valid/ready handshake.
- Handles branch/jump redirects (queue flush) from execute and a halt request.

Parameters:
RESET_PC, 0, word address fetched first after reset
FIFO_DEPTH, 2, fetch-queue entries; power of two, >= 2
ADDR_W, 8, width of InstAddrBus (word-addressed PC)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
rom_addr_o  output  InstAddrBus  word address to ROM (pc_i)
rom_inst_i  input  InstBus  ROM data for rom_addr_o, same cycle
halt_i  input  1  stop issuing new fetches; queue still drains
redirect_i  input  1  branch/jump taken; flush and restart fetch
redirect_pc_i  input  InstAddrBus  new word address, valid with redirect_i
if_valid_o  output  1  queue head valid toward decode
if_ready_i  input  1  decode accepts head
if_pc_o  output  InstAddrBus  PC of head entry
if_inst_o  output  InstBus  instruction of head entry; INST_NOP when not valid
fetch_cnt_o  output  32  count of instructions handed to decode

Behaviour:
- Reset (async, rst=1):
  - fetch_pc = RESET_PC; queue empty.
  - if_valid_o=0, if_pc_o=0, if_inst_o=INST_NOP (32'h0000_0013), fetch_cnt_o=0.
  - rom_addr_o=RESET_PC.
- ROM interface: rom_addr_o = fetch_pc (combinational from register). ROM is zero-latency; rom_inst_i is sampled the same cycle.
- pop = if_valid_o & if_ready_i.
- push = !halt_i & !redirect_i & (count < FIFO_DEPTH | pop).
  - Push when full is allowed if a pop occurs in the same cycle.
- On push:
  - Enqueue {fetch_pc, rom_inst_i}.
  - fetch_pc <= fetch_pc + 1, modulo 2^ADDR_W (255 -> 0 wraps silently).
- Latency: first cycle after rst deasserts pushes addr RESET_PC; if_valid_o=1 on the next cycle. Steady state is 1 instruction/cycle with if_ready_i held high.
- Back-pressure: while if_ready_i=0, head, if_pc_o and if_inst_o are held stable. The queue fills to FIFO_DEPTH, then fetch_pc freezes.
- Redirect (highest priority):
  - if_valid_o is forced 0 combinationally in the redirect cycle, so no transfer occurs and fetch_cnt_o does not increment.
  - Queue is flushed at the clock edge; fetch_pc <= redirect_pc_i.
  - Next cycle fetches redirect_pc_i; valid one cycle after that (2-cycle redirect penalty).
  - Redirect with halt_i=1: PC still updated, nothing fetched.
- Halt: no push; entries already queued still drain. Deasserting halt resumes at the held fetch_pc.
- fetch_cnt_o increments by 1 on each pop; wraps at 2^32.
- Simultaneous push+pop: count unchanged; pointers both advance and wrap mod FIFO_DEPTH.
- Reset mid-operation: all state returns to reset values immediately (async). In-flight entries are discarded.
- Single state machine with states RUN, HALT, REDIRECT:
  - REDIRECT lasts exactly the redirect cycle; it is encoded implicitly by redirect_i.
  - HALT while halt_i=1.
  - Otherwise RUN.

Decomposition:
- type_pkg: add fetch_entry_t (struct {InstAddrBus pc; InstBus inst;}).
- defines.sv: add INST_NOP = 32'h0000_0013 and RESET_PC default.
- Sub-module fetch_fifo holds the queue:
  - Parameterised on FIFO_DEPTH and element type fetch_entry_t.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - flush has priority over push in the same cycle.
- inst_fetch_ctrl holds the PC, push/pop control and the counter.

Test Plan:
- Reset, then if_ready_i=1 with ROM program loaded:
  - cycle 1: if_pc_o=0, if_inst_o=32'h0000_0013.
  - cycle 2: if_pc_o=1, if_inst_o=32'h00F0_8093.
  - cycle 4: if_pc_o=3, if_inst_o=32'h0020_80B3.
  - fetch_cnt_o=4 after 4 pops.
- Hold if_ready_i=0 for 5 cycles from pc 3:
  - head stays pc 3 / 32'h0020_80B3.
  - rom_addr_o freezes at 5 (queue holds pc 3,4).
  - Release: pcs 3,4,5 delivered in order, no gaps.
- Queue full (pc 8,9 held), assert redirect_i with redirect_pc_i=0:
  - if_valid_o=0 that cycle.
  - next cycle rom_addr_o=0; then if_pc_o=0; pcs 8,9 are never delivered.
- Redirect to 254, ready high: delivered pcs 254, 255, 0, 1 (wrap); if_inst_o for pc 254 = INST_NOP (ROM default).
- halt_i=1 for 3 cycles with 2 entries queued: both entries drain, then if_valid_o=0 and rom_addr_o constant. Release: fetch resumes at the same address.
- Assert rst mid-stream at pc 6 for one cycle: if_valid_o=0 and fetch_cnt_o=0 immediately; pc 0 is delivered 2 cycles after rst falls.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
//   InstAddrBus   : word-addressed PC / ROM address
//   InstBus       : 32-bit instruction word
//   fetch_entry_t : one fetch-queue entry {pc, inst}
//   ST_*          : fetch sequencer state codes
package inst_fetch_ctrl_pkg;

    localparam int unsigned INST_ADDR_W = 8;
    localparam int unsigned INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] InstAddrBus;
    typedef logic [INST_W-1:0]      InstBus;

    localparam InstBus     INST_NOP         = 32'h0000_0013;
    localparam InstAddrBus RESET_PC_DEFAULT = '0;

    typedef struct packed {
        InstAddrBus pc;
        InstBus     inst;
    } fetch_entry_t;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_HALT     = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// ROM and decode-side bus of the fetch sequencer.
//   rom_addr_o  : word address to the ROM
//   rom_inst_i  : ROM data for rom_addr_o, same cycle
//   if_valid_o  : queue head valid toward decode
//   if_ready_i  : decode accepts head
//   if_pc_o     : PC of head entry
//   if_inst_o   : instruction of head entry (INST_NOP when not valid)
// master = fetch sequencer, slave = ROM + decode.
interface inst_fetch_ctrl_if
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = INST_ADDR_W
) ();

    logic [ADDR_W-1:0] rom_addr_o;
    InstBus            rom_inst_i;
    logic              if_valid_o;
    logic              if_ready_i;
    logic [ADDR_W-1:0] if_pc_o;
    InstBus            if_inst_o;

    modport master (
        output rom_addr_o,
        input  rom_inst_i,
        output if_valid_o,
        input  if_ready_i,
        output if_pc_o,
        output if_inst_o
    );

    modport slave (
        input  rom_addr_o,
        output rom_inst_i,
        input  if_valid_o,
        output if_ready_i,
        input  if_pc_o,
        input  if_inst_o
    );

endinterface

// File: rtl/inst_fetch_ctrl_fetch_fifo.sv
// Fetch queue: small circular FIFO of fetch entries.
//   clk, rst : clock, asynchronous active-high reset
//   push     : enqueue din (ignored when full unless pop in same cycle)
//   pop      : dequeue head (ignored when empty)
//   flush    : discard all entries; wins over push/pop
//   din      : entry to enqueue
//   dout     : head entry (undefined when empty)
//   count    : number of entries held
//   full     : count == FIFO_DEPTH
//   empty    : count == 0
module inst_fetch_ctrl_fetch_fifo
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter type         T          = fetch_entry_t
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  T                              din,
    output T                              dout,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    T                 mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == CNT_W'(FIFO_DEPTH));
    assign empty   = (cnt == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer for a zero-latency instruction ROM.
// Owns the fetch PC, queues {pc, inst} pairs and hands them to decode over
// valid/ready. Redirects flush the queue and restart fetch; halt stops new
// fetches while the queue drains.
//   clk, rst      : clock, asynchronous active-high reset
//   bus           : ROM address/data and decode handshake (master side)
//   halt_i        : stop issuing new fetches
//   redirect_i    : branch/jump taken; flush and restart at redirect_pc_i
//   redirect_pc_i : new word address, valid with redirect_i
//   fetch_cnt_o   : instructions handed to decode (wraps at 2^32)
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned ADDR_W     = INST_ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    inst_fetch_ctrl_if.master   bus,
    input  logic                halt_i,
    input  logic                redirect_i,
    input  logic [ADDR_W-1:0]   redirect_pc_i,
    output logic [31:0]         fetch_cnt_o
);

    localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        InstBus            inst;
    } entry_t;

    logic [ADDR_W-1:0]           fetch_pc;
    logic [1:0]                  state;
    logic                        push;
    logic                        pop;
    logic                        head_valid;
    entry_t                      push_entry;
    entry_t                      head_entry;
    logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
    logic                        fifo_full;
    logic                        fifo_empty;

    // REDIRECT lives only for the redirect cycle, so the state is decoded
    // straight from the inputs rather than registered.
    always_comb begin
        state = ST_RUN;
        if (redirect_i)  state = ST_REDIRECT;
        else if (halt_i) state = ST_HALT;
    end

    assign head_valid = ~fifo_empty & (state != ST_REDIRECT);
    assign pop        = head_valid & bus.if_ready_i;
    assign push       = (state == ST_RUN) & (~fifo_full | pop);
    assign push_entry = '{pc: fetch_pc, inst: bus.rom_inst_i};

    inst_fetch_ctrl_fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .T          (entry_t)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .din   (push_entry),
        .dout  (head_entry),
        .count (unused_fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC_W;
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_i;
        end else if (push) begin
            fetch_pc <= fetch_pc + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_o <= '0;
        end else if (pop) begin
            fetch_cnt_o <= fetch_cnt_o + 32'd1;
        end
    end

    assign bus.rom_addr_o = fetch_pc;
    assign bus.if_valid_o = head_valid;
    assign bus.if_pc_o    = head_valid ? head_entry.pc   : '0;
    assign bus.if_inst_o  = head_valid ? head_entry.inst : INST_NOP;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios followed by a
// randomized run, all compared against a queue-based reference model.
module tb_inst_fetch_ctrl;
    import inst_fetch_ctrl_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned AW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          halt;
    logic          redirect;
    logic          ready;
    logic [AW-1:0] redirect_pc;
    logic [31:0]   fetch_cnt;
    logic [31:0]   rom [256];

    inst_fetch_ctrl_if #(.ADDR_W(AW)) bus ();

    assign bus.rom_inst_i = rom[bus.rom_addr_o];
    assign bus.if_ready_i = ready;

    inst_fetch_ctrl #(
        .RESET_PC   (0),
        .FIFO_DEPTH (DEPTH),
        .ADDR_W     (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .halt_i        (halt),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .fetch_cnt_o   (fetch_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of {pc, inst}, the fetch address, and a
    // delivery counter.
    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   inst;
    } ent_t;

    ent_t          mq[$];
    logic [AW-1:0] mpc;
    logic [31:0]   mcnt;
    logic [AW-1:0] got_pc[$];
    logic [31:0]   got_inst[$];
    int unsigned   vectors     = 0;
    int unsigned   miscompares = 0;

    wire [48:0] dut_vec = {bus.if_valid_o, bus.if_pc_o, bus.if_inst_o, bus.rom_addr_o};

    function automatic logic [48:0] exp_vec();
        logic [48:0] e;
        e = {1'b0, 8'h00, INST_NOP, mpc};
        if (mq.size() != 0 && !redirect) e = {1'b1, mq[0].pc, mq[0].inst, mpc};
        return e;
    endfunction

    task automatic model_reset();
        mq.delete();
        mpc  = '0;
        mcnt = '0;
    endtask

    task automatic drive(input logic h, input logic r, input logic [AW-1:0] rp, input logic rdy);
        halt        = h;
        redirect    = r;
        redirect_pc = rp;
        ready       = rdy;
        #1;
    endtask

    // Records what the DUT hands to decode, advances the model by one clock
    // using the rules as stated, then moves to the next falling edge.
    task automatic tick();
        logic v, p_pop, p_push;
        if (bus.if_valid_o && ready) begin
            got_pc.push_back(bus.if_pc_o);
            got_inst.push_back(bus.if_inst_o);
        end
        v      = (mq.size() != 0) && !redirect;
        p_pop  = v && ready;
        p_push = !halt && !redirect && ((mq.size() < DEPTH) || p_pop);
        if (redirect) begin
            mq.delete();
            mpc = redirect_pc;
        end else begin
            if (p_pop) begin
                void'(mq.pop_front());
                mcnt = mcnt + 32'd1;
            end
            if (p_push) begin
                mq.push_back('{pc: mpc, inst: rom[mpc]});
                mpc = mpc + 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_got();
        got_pc.delete();
        got_inst.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (dut_vec !== {1'b0, 8'h00, INST_NOP, 8'h00}) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h required %h", dut_vec, {1'b0, 8'h00, INST_NOP, 8'h00});
        end
        vectors++;
        if (fetch_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %0d required 0", fetch_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        clear_got();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL stream c%0d: got %h required %h", i, dut_vec, exp_vec());
            end
            tick();
        end
        vectors++;
        if (got_pc.size() != 3 || got_pc[0] !== 8'd0 || got_pc[1] !== 8'd1 || got_pc[2] !== 8'd2
            || got_inst[0] !== 32'h0000_0013 || got_inst[1] !== 32'h00F0_8093) begin
            miscompares++;
            $display("FAIL stream_order: got pcs %p insts %p required pcs 0,1,2 insts 00000013,00f08093,..", got_pc, got_inst);
        end
        #1;
        vectors++;
        if (fetch_cnt !== 32'd3) begin
            miscompares++;
            $display("FAIL stream_cnt: got %0d required 3", fetch_cnt);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL bp_hold c%0d: got %h required %h", i, dut_vec, exp_vec());
            end
            vectors++;
            if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 8'd3 || bus.if_inst_o !== 32'h0020_80B3
                || (i >= 1 && bus.rom_addr_o !== 8'd5)) begin
                miscompares++;
                $display("FAIL bp_head c%0d: got v=%b pc=%0d inst=%h addr=%0d required v=1 pc=3 inst=002080b3 addr=5",
                         i, bus.if_valid_o, bus.if_pc_o, bus.if_inst_o, bus.rom_addr_o);
            end
            tick();
        end
        clear_got();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL bp_release c%0d: got %h required %h", i, dut_vec, exp_vec());
            end
            if (i == 1) begin
                vectors++;
                if (fetch_cnt !== 32'd4) begin
                    miscompares++;
                    $display("FAIL bp_cnt: got %0d required 4", fetch_cnt);
                end
            end
            tick();
        end
        vectors++;
        if (got_pc.size() != 3 || got_pc[0] !== 8'd3 || got_pc[1] !== 8'd4 || got_pc[2] !== 8'd5) begin
            miscompares++;
            $display("FAIL bp_order: got %p required 3,4,5", got_pc);
        end
    endtask

    task automatic test_redirect_flush();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL flush_fill c%0d: got %h required %h", i, dut_vec, exp_vec());
            end
            tick();
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if (bus.if_pc_o !== 8'd8 || bus.rom_addr_o !== 8'd10 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL flush_full: got pc=%0d addr=%0d required pc=8 addr=10", bus.if_pc_o, bus.rom_addr_o);
        end
        tick();
        clear_got();
        drive(1'b0, 1'b1, 8'd0, 1'b1);
        vectors++;
        if (bus.if_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_valid: got %b required 0", bus.if_valid_o);
        end
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (bus.rom_addr_o !== 8'd0 || bus.if_valid_o !== 1'b0 || fetch_cnt !== 32'd8) begin
            miscompares++;
            $display("FAIL flush_restart: got addr=%0d v=%b cnt=%0d required addr=0 v=0 cnt=8",
                     bus.rom_addr_o, bus.if_valid_o, fetch_cnt);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL flush_run c%0d: got %h required %h", i, dut_vec, exp_vec());
            end
            tick();
        end
        vectors++;
        if (got_pc.size() != 4 || got_pc[0] !== 8'd0 || got_pc[1] !== 8'd1 || got_pc[2] !== 8'd2 || got_pc[3] !== 8'd3) begin
            miscompares++;
            $display("FAIL flush_order: got %p required 0,1,2,3", got_pc);
        end
    endtask

    task automatic test_wrap();
        clear_got();
        drive(1'b0, 1'b1, 8'd254, 1'b1);
        vectors++;
        if (dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL wrap_redirect: got %h required %h", dut_vec, exp_vec());
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1);
            vectors++;
            if (dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL wrap_run c%0d: got %h required %h", i, dut_vec, exp_vec());
            end
            tick();
        end
        vectors++;
        if (got_pc.size() != 4 || got_pc[0] !== 8'd254 || got_pc[1] !== 8'd255 || got_pc[2] !== 8'd0
            || got_pc[3] !== 8'd1 || got_inst[0] !== INST_NOP) begin
            miscompares++;
            $display("FAIL wrap_order: got %p inst0=%h required 254,255,0,1 inst0=00000013", got_pc, got_inst[0]);
        end
    endtask

    task automatic test_halt();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, '0, 1'b0);
            tick();
        end
        clear_got();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, '0, 1'b1);
            vectors++;
            if (dut_vec !== exp_vec() || bus.rom_addr_o !== 8'd4 || (i == 2 && bus.if_valid_o !== 1'b0)) begin
                miscompares++;
                $display("FAIL halt_drain c%0d: got %h required %h (addr 4)", i, dut_vec, exp_vec());
            end
            tick();
        end
        vectors++;
        if (got_pc.size() != 2 || got_pc[0] !== 8'd2 || got_pc[1] !== 8'd3) begin
            miscompares++;
            $display("FAIL halt_order: got %p required 2,3", got_pc);
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 8'd4 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL halt_resume: got v=%b pc=%0d required v=1 pc=4", bus.if_valid_o, bus.if_pc_o);
        end
        // Redirect while halted: PC moves, nothing is fetched.
        drive(1'b1, 1'b1, 8'h40, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, '0, 1'b1);
            vectors++;
            if (bus.rom_addr_o !== 8'h40 || bus.if_valid_o !== 1'b0 || dut_vec !== exp_vec()) begin
                miscompares++;
                $display("FAIL halt_redirect c%0d: got addr=%h v=%b required addr=40 v=0", i, bus.rom_addr_o, bus.if_valid_o);
            end
            tick();
        end
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, 8'd6, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (bus.if_pc_o !== 8'd6 || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL rstmid_pre: got %h required %h (pc 6)", dut_vec, exp_vec());
        end
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (bus.if_valid_o !== 1'b0 || fetch_cnt !== 32'd0 || bus.rom_addr_o !== 8'd0) begin
            miscompares++;
            $display("FAIL rstmid_async: got v=%b cnt=%0d addr=%0d required v=0 cnt=0 addr=0",
                     bus.if_valid_o, fetch_cnt, bus.rom_addr_o);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b1);
        tick();
        drive(1'b0, 1'b0, '0, 1'b1);
        vectors++;
        if (bus.if_valid_o !== 1'b1 || bus.if_pc_o !== 8'd0 || bus.if_inst_o !== INST_NOP || dut_vec !== exp_vec()) begin
            miscompares++;
            $display("FAIL rstmid_restart: got v=%b pc=%0d inst=%h required v=1 pc=0 inst=00000013",
                     bus.if_valid_o, bus.if_pc_o, bus.if_inst_o);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, AW'($urandom), $urandom_range(0, 9) < 6);
            vectors++;
            if (dut_vec !== exp_vec() || fetch_cnt !== mcnt) begin
                miscompares++;
                $display("FAIL random c%0d: got %h cnt=%0d required %h cnt=%0d", i, dut_vec, fetch_cnt, exp_vec(), mcnt);
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = INST_NOP;
        rom[1] = 32'h00F0_8093;
        rom[2] = 32'h0020_8113;
        rom[3] = 32'h0020_80B3;
        for (int i = 4; i < 200; i++) rom[i] = $urandom;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
